// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline-boundary registers: bundle widths for each
// stage boundary and the occupancy encoding used by pipe_stage_reg.
package pipe_pkg;

    // Bundle widths per pipeline boundary (callers pack/unpack their own fields)
    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_CTRL_W  = 8;
    localparam int IDEX_DATA_W  = 106;
    localparam int EXMEM_CTRL_W = 5;
    localparam int EXMEM_DATA_W = 70;
    localparam int MEMWB_CTRL_W = 3;
    localparam int MEMWB_DATA_W = 38;

    // Occupancy encoding: number of held entries
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic flushable pipeline stage register with valid/ready handshake.
// SKID=1 adds a second slot so In_Ready can be registered (no combinational
// path from Out_Ready back upstream); SKID=0 is a single slot with a
// combinational ready. The head is always the main slot; order is FIFO.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 38,
    parameter int SKID   = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    output logic [1:0]        Occupancy
);

    logic [1:0]        occ;
    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_ready_w;

    logic              in_xfer;
    logic              out_xfer;
    logic [1:0]        nxt_occ;
    logic              nxt_valid;
    logic              ld_main_in;
    logic              ld_main_skid;
    logic              ld_skid;

    assign in_xfer  = In_Valid && in_ready_w;
    assign out_xfer = main_valid && Out_Ready;

    // Next occupancy and slot-load strobes; Flush overrides every transition
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        nxt_occ      = occ;
        nxt_valid    = main_valid;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (Flush) begin
            nxt_occ   = OCC_EMPTY;
            nxt_valid = 1'b0;
        end else if (SKID != 0) begin
            case (occ)
                OCC_EMPTY: begin
                    if (in_xfer) begin
                        nxt_occ    = OCC_ONE;
                        nxt_valid  = 1'b1;
                        ld_main_in = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (in_xfer && out_xfer) begin
                        ld_main_in = 1'b1;
                    end else if (in_xfer) begin
                        nxt_occ = OCC_FULL;
                        ld_skid = 1'b1;
                    end else if (out_xfer) begin
                        nxt_occ   = OCC_EMPTY;
                        nxt_valid = 1'b0;
                    end
                end
                OCC_FULL: begin
                    // In_Ready is low here, so only the drain side can move
                    if (out_xfer) begin
                        nxt_occ      = OCC_ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: begin
                    nxt_occ   = OCC_EMPTY;
                    nxt_valid = 1'b0;
                end
            endcase
        end else begin
            if (in_xfer) begin
                nxt_occ    = OCC_ONE;
                nxt_valid  = 1'b1;
                ld_main_in = 1'b1;
            end else if (out_xfer) begin
                nxt_occ   = OCC_EMPTY;
                nxt_valid = 1'b0;
            end
        end
    end

    // Head (main) slot and occupancy; the head data resets so Out_Data starts at zero
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            occ        <= OCC_EMPTY;
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
        end else begin
            occ        <= nxt_occ;
            main_valid <= nxt_valid;
            if (ld_main_in) begin
                main_ctrl <= In_Ctrl;
                main_data <= In_Data;
            end else if (ld_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            // Skid slot payload; its validity is carried by occ, so no reset is needed
            // NOTE: storage qualified by a separately reset valid/occupancy is left unreset.
            always_ff @(posedge Clk) begin
                if (ld_skid) begin
                    skid_ctrl <= In_Ctrl;
                    skid_data <= In_Data;
                end
            end

            // Registered ready: accept whenever the next state leaves room
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (nxt_occ != OCC_FULL);
                end
            end

            assign in_ready_w = in_ready_q;
        end else begin : g_noskid
            assign skid_ctrl  = '0;
            assign skid_data  = '0;
            assign in_ready_w = !main_valid || Out_Ready;
        end
    endgenerate

    assign In_Ready  = in_ready_w;
    assign Out_Valid = main_valid;
    // Bubbles never present live control bits downstream
    assign Out_Ctrl  = main_valid ? main_ctrl : '0;
    assign Out_Data  = main_data;
    assign Occupancy = occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one SKID=1 instance (a_*) and one
// SKID=0 instance (b_*) on a shared clock, expected values written by hand.
module tb_pipe_stage_reg;

    localparam int CW = 3;
    localparam int DW = 38;

    logic          Clk;
    logic          Rst_n;

    logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [1:0]    a_occ;

    logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [1:0]    b_occ;

    int n_compared;
    int n_mismatched;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_skid (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(a_flush),
        .In_Valid(a_in_valid), .In_Ready(a_in_ready),
        .In_Ctrl(a_in_ctrl), .In_Data(a_in_data),
        .Out_Valid(a_out_valid), .Out_Ready(a_out_ready),
        .Out_Ctrl(a_out_ctrl), .Out_Data(a_out_data),
        .Occupancy(a_occ)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_noskid (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(b_flush),
        .In_Valid(b_in_valid), .In_Ready(b_in_ready),
        .In_Ctrl(b_in_ctrl), .In_Data(b_in_data),
        .Out_Valid(b_out_valid), .Out_Ready(b_out_ready),
        .Out_Ctrl(b_out_ctrl), .Out_Data(b_out_data),
        .Occupancy(b_occ)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        Rst_n = 1'b0;
        a_flush = 0; a_in_valid = 0; a_out_ready = 1; a_in_ctrl = '0; a_in_data = '0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 1; b_in_ctrl = '0; b_in_data = '0;

        // ---- reset state ----
        #12;
        check("rst_a_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_ctrl",  64'(a_out_ctrl),  64'd0);
        check("rst_a_occ",   64'(a_occ),       64'd0);
        check("rst_a_ready", 64'(a_in_ready),  64'd1);
        check("rst_a_data",  64'(a_out_data),  64'd0);
        check("rst_b_ready", 64'(b_in_ready),  64'd1);
        check("rst_b_valid", 64'(b_out_valid), 64'd0);
        Rst_n = 1'b1;
        step();

        // ---- stream, SKID=1: 0x11..0x14, ctrl 101, one per cycle ----
        a_in_ctrl = 3'b101;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1;
            a_in_data  = DW'(8'h11 + i);
            step();
            check("stream_valid", 64'(a_out_valid), 64'd1);
            check("stream_data",  64'(a_out_data),  64'h11 + 64'(i));
            check("stream_ctrl",  64'(a_out_ctrl),  64'h5);
            check("stream_occ",   64'(a_occ),       64'd1);
        end
        a_in_valid = 0;
        step();
        check("stream_drain_valid", 64'(a_out_valid), 64'd0);
        check("stream_drain_ctrl",  64'(a_out_ctrl),  64'd0);

        // ---- stall into skid ----
        a_in_ctrl = 3'b010;
        a_in_valid = 1; a_in_data = DW'(8'h0A);
        step();
        check("skid_a_loaded", 64'(a_out_data), 64'h0A);
        a_out_ready = 0; a_in_data = DW'(8'h0B);
        step();
        a_in_valid = 0;
        check("skid_occ_full",  64'(a_occ),       64'd2);
        check("skid_ready_low", 64'(a_in_ready),  64'd0);
        check("skid_head_a",    64'(a_out_data),  64'h0A);
        step();
        check("skid_hold_a",    64'(a_out_data),  64'h0A);
        check("skid_hold_occ",  64'(a_occ),       64'd2);
        a_out_ready = 1;
        step();
        check("skid_then_b",    64'(a_out_data),  64'h0B);
        check("skid_b_valid",   64'(a_out_valid), 64'd1);
        check("skid_occ_one",   64'(a_occ),       64'd1);
        check("skid_ready_back",64'(a_in_ready),  64'd1);
        step();
        check("skid_empty",     64'(a_out_valid), 64'd0);

        // ---- flush while full; 0x0C offered with Flush ----
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = DW'(8'h21);
        step();
        a_in_data = DW'(8'h22);
        step();
        check("flush_pre_occ", 64'(a_occ), 64'd2);
        a_flush = 1; a_in_data = DW'(8'h0C);
        step();
        a_flush = 0; a_in_valid = 0;
        check("flush_occ",   64'(a_occ),       64'd0);
        check("flush_valid", 64'(a_out_valid), 64'd0);
        check("flush_ctrl",  64'(a_out_ctrl),  64'd0);
        a_out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_no_0c", 64'(a_out_valid), 64'd0);
        end

        // ---- flush from ONE with an accepted input: entry is discarded ----
        a_in_valid = 1; a_in_data = DW'(8'h31);
        step();
        a_flush = 1; a_in_data = DW'(8'h32);
        step();
        a_flush = 0; a_in_valid = 0;
        check("flush1_valid", 64'(a_out_valid), 64'd0);
        check("flush1_occ",   64'(a_occ),       64'd0);

        // ---- bubble gating ----
        a_in_ctrl = 3'b111; b_in_ctrl = 3'b111;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bubble_a_ctrl", 64'(a_out_ctrl), 64'd0);
            check("bubble_b_ctrl", 64'(b_out_ctrl), 64'd0);
        end

        // ---- SKID=0 stall ----
        b_in_ctrl = 3'b001; b_in_valid = 1; b_in_data = DW'(8'h55);
        step();
        b_out_ready = 0;
        b_in_data = DW'(8'h66);   // offered during stall, must not be taken
        #1;
        check("b_ready_same_cycle", 64'(b_in_ready), 64'd0);
        check("b_occ_one",          64'(b_occ),      64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("b_hold_data",  64'(b_out_data),  64'h55);
            check("b_hold_valid", 64'(b_out_valid), 64'd1);
            check("b_hold_ctrl",  64'(b_out_ctrl),  64'h1);
        end
        b_in_valid = 0; b_out_ready = 1;
        #1;
        check("b_ready_release", 64'(b_in_ready), 64'd1);
        step();
        check("b_drained", 64'(b_out_valid), 64'd0);
        check("b_occ_zero", 64'(b_occ),      64'd0);

        // ---- SKID=0 throughput ----
        for (int i = 0; i < 3; i++) begin
            b_in_valid = 1; b_in_data = DW'(8'h40 + i);
            step();
            check("b_stream_data",  64'(b_out_data),  64'h40 + 64'(i));
            check("b_stream_valid", 64'(b_out_valid), 64'd1);
        end
        b_in_valid = 0;

        // ---- async reset mid-stream ----
        a_in_ctrl = 3'b101; a_in_valid = 1; a_in_data = DW'(8'h71);
        step();
        check("arst_pre_data", 64'(a_out_data), 64'h71);
        a_in_data = DW'(8'h72);
        #3;
        Rst_n = 0;
        #1;
        check("arst_a_valid", 64'(a_out_valid), 64'd0);
        check("arst_a_occ",   64'(a_occ),       64'd0);
        check("arst_a_ctrl",  64'(a_out_ctrl),  64'd0);
        check("arst_b_valid", 64'(b_out_valid), 64'd0);
        a_in_data = DW'(8'h73);
        #1;
        Rst_n = 1;
        step();
        check("arst_first_valid", 64'(a_out_valid), 64'd1);
        check("arst_first_data",  64'(a_out_data),  64'h73);
        a_in_valid = 0;
        step();
        check("arst_no_dup", 64'(a_out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
